rs_syndrome_checker: RTL and testbench

//  Receive-side companion to the RS(255,247) encoder: GF(256), p(x)=x^8+x^4+x^3+x^2+1, alpha=8'h02, roots alpha^1..alpha^8.

---
 rtl/rs_syndrome_checker.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_rs_syndrome_checker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_syndrome_checker.sv
// RS(255,247) receive-side syndrome checker: computes S1..S8 per codeword, buffers
// the frame in one of two banks, replays the data symbols with the 8 parity symbols stripped.
// Latency: first data symbol 2 cycles after din_eop (read side idle); no output backpressure.
// Backpressure: busy=1 when both banks are occupied; a sop while busy is dropped with an ovf pulse.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   din_val/din_sop/din_eop/din      codeword input, highest-degree symbol first, parity last
//   dout_val/dout_sop/dout_eop/dout  replayed data symbols, gap-free within a frame
//   err, syn                         valid with dout_eop: any syndrome nonzero, {S8..S1}
//   len_err, ovf                     1-cycle pulses: frame dropped for bad length / for arriving while busy
//   busy                             both banks occupied
module rs_syndrome_checker #(
   parameter int NPAR = 8,
   parameter int NMAX = 255,
   parameter int AW   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        din_val,
   input  logic        din_sop,
   input  logic        din_eop,
   input  logic [7:0]  din,
   output logic        dout_val,
   output logic        dout_sop,
   output logic        dout_eop,
   output logic [7:0]  dout,
   output logic        err,
   output logic [63:0] syn,
   output logic        len_err,
   output logic        ovf,
   output logic        busy
);

   // alpha^1..alpha^8, alpha^(k+1) in bits [8k+7:8k]
   localparam logic [63:0] ALPHA = 64'h1D80_4020_1008_0402;
   localparam logic [8:0]  NMAX9 = 9'(NMAX);

   localparam logic [1:0] W_IDLE = 2'd0, W_RECV = 2'd1, W_DROP = 2'd2;
   localparam logic       R_IDLE = 1'b0, R_PLAY = 1'b1;
   localparam logic [1:0] B_FREE = 2'd0, B_WR = 2'd1, B_CMT = 2'd2, B_PLAY = 2'd3;

   function automatic logic [7:0] gf256mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
      end
      return p;
   endfunction

   // write side
   logic [1:0]        wst_q, wst_d;
   logic [8:0]        cnt_q, cnt_d;
   logic              ovl_q, ovl_d;
   logic              wbank_q, wbank_d;
   logic [63:0]       s_q, s_d, s_horner;
   logic              len_err_q, len_err_d, ovf_q, ovf_d;
   logic              we, wsel, free_bank, any_free;
   logic [AW-1:0]     waddr;
   logic              wr_alloc, wr_commit, wr_release;
   // bank bookkeeping: state, last read address (N-9), final syndromes
   logic [1:0][1:0]   bst_q, bst_d;
   logic [1:0][AW-1:0] blen_q, blen_d;
   logic [1:0][63:0]  bsyn_q, bsyn_d;
   logic              busy_q, busy_d;
   // read side
   logic              rdst_q, rdst_d;
   logic              rd_bank_q, rd_bank_d;
   logic [AW-1:0]     rd_cnt_q, rd_cnt_d, rd_last_q, rd_last_d;
   logic              iss, iss_bank, iss_last, oth_bank, cmt_bank, any_cmt;
   logic [AW-1:0]     iss_addr;
   logic              rd_take, rd_take_bank, rd_done;
   logic              dout_val_q, dout_val_d, dout_sop_q, dout_sop_d, dout_eop_q, dout_eop_d;
   logic              err_q, err_d;
   logic [63:0]       syn_q, syn_d;
   logic [7:0]        rd_dat_q;
   logic [7:0]        mem [0:(2**(AW+1))-1];

   always_comb begin
      s_horner = '0;
      for (int k = 0; k < 8; k++)
         s_horner[8*k +: 8] = gf256mul(s_q[8*k +: 8], ALPHA[8*k +: 8]) ^ din;
   end

   // write FSM next state and datapath
   always_comb begin
      wst_d      = wst_q;
      cnt_d      = cnt_q;
      ovl_d      = ovl_q;
      wbank_d    = wbank_q;
      s_d        = s_q;
      len_err_d  = 1'b0;
      ovf_d      = 1'b0;
      we         = 1'b0;
      waddr      = cnt_q[AW-1:0];
      wr_alloc   = 1'b0;
      wr_commit  = 1'b0;
      wr_release = 1'b0;
      any_free   = (bst_q[0] == B_FREE) || (bst_q[1] == B_FREE);
      free_bank  = (bst_q[0] == B_FREE) ? 1'b0 : 1'b1;
      case (wst_q)
         W_IDLE: if (din_val && din_sop) begin
            if (!any_free) begin
               ovf_d = 1'b1;
               if (!din_eop) wst_d = W_DROP;
            end else if (din_eop) begin
               len_err_d = 1'b1;
            end else begin
               wst_d    = W_RECV;
               wbank_d  = free_bank;
               wr_alloc = 1'b1;
               cnt_d    = 9'd1;
               ovl_d    = 1'b0;
               s_d      = {8{din}};
               we       = 1'b1;
               waddr    = '0;
            end
         end
         W_RECV: if (din_val) begin
            if (din_sop) begin
               // restart in the same bank; the partial frame is silently discarded
               s_d   = {8{din}};
               cnt_d = 9'd1;
               ovl_d = 1'b0;
               we    = 1'b1;
               waddr = '0;
               if (din_eop) begin
                  len_err_d  = 1'b1;
                  wr_release = 1'b1;
                  wst_d      = W_IDLE;
               end
            end else begin
               s_d = s_horner;
               if (cnt_q < NMAX9) begin
                  we    = 1'b1;
                  cnt_d = cnt_q + 9'd1;
               end else begin
                  ovl_d = 1'b1;
               end
               if (din_eop) begin
                  wst_d = W_IDLE;
                  // N = cnt_q+1 must lie in [NPAR+1, NMAX]
                  if (ovl_q || (cnt_q >= NMAX9) || (cnt_q < 9'(NPAR))) begin
                     len_err_d  = 1'b1;
                     wr_release = 1'b1;
                  end else begin
                     wr_commit = 1'b1;
                  end
               end
            end
         end
         W_DROP: if (din_val && din_eop) wst_d = W_IDLE;
         default: wst_d = W_IDLE;
      endcase
      wsel = wr_alloc ? free_bank : wbank_q;
   end

   // read FSM next state; memory address is issued combinationally so a commit
   // seen this cycle yields dout_sop next cycle
   always_comb begin
      rdst_d       = rdst_q;
      rd_bank_d    = rd_bank_q;
      rd_cnt_d     = rd_cnt_q;
      rd_last_d    = rd_last_q;
      iss          = 1'b0;
      iss_bank     = rd_bank_q;
      iss_addr     = rd_cnt_q;
      iss_last     = 1'b0;
      rd_take      = 1'b0;
      rd_take_bank = 1'b0;
      rd_done      = 1'b0;
      any_cmt      = (bst_q[0] == B_CMT) || (bst_q[1] == B_CMT);
      cmt_bank     = (bst_q[0] == B_CMT) ? 1'b0 : 1'b1;
      if (rdst_q == R_PLAY) begin
         iss      = 1'b1;
         iss_last = (rd_cnt_q == rd_last_q);
      end else if (any_cmt) begin
         iss          = 1'b1;
         iss_bank     = cmt_bank;
         iss_addr     = '0;
         iss_last     = (blen_q[cmt_bank] == '0);
         rd_take      = 1'b1;
         rd_take_bank = cmt_bank;
         rd_last_d    = blen_q[cmt_bank];
      end
      oth_bank = ~iss_bank;
      if (iss) begin
         if (!iss_last) begin
            rdst_d    = R_PLAY;
            rd_bank_d = iss_bank;
            rd_cnt_d  = iss_addr + 1'b1;
         end else begin
            rd_done = 1'b1;
            if (bst_q[oth_bank] == B_CMT) begin
               rdst_d       = R_PLAY;
               rd_bank_d    = oth_bank;
               rd_cnt_d     = '0;
               rd_last_d    = blen_q[oth_bank];
               rd_take      = 1'b1;
               rd_take_bank = oth_bank;
            end else begin
               rdst_d = R_IDLE;
            end
         end
      end
   end

   // bank state merge and registered outputs
   always_comb begin
      bst_d  = bst_q;
      blen_d = blen_q;
      bsyn_d = bsyn_q;
      if (rd_done)    bst_d[iss_bank]     = B_FREE;
      if (rd_take)    bst_d[rd_take_bank] = B_PLAY;
      if (wr_alloc)   bst_d[free_bank]    = B_WR;
      if (wr_release) bst_d[wbank_q]      = B_FREE;
      if (wr_commit) begin
         bst_d[wbank_q]  = B_CMT;
         blen_d[wbank_q] = AW'(cnt_q - 9'(NPAR));
         bsyn_d[wbank_q] = s_horner;
      end
      busy_d     = (bst_d[0] != B_FREE) && (bst_d[1] != B_FREE);
      dout_val_d = iss;
      dout_sop_d = iss && (iss_addr == '0);
      dout_eop_d = iss && iss_last;
      err_d      = iss && iss_last && (bsyn_q[iss_bank] != 64'd0);
      syn_d      = (iss && iss_last) ? bsyn_q[iss_bank] : 64'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wst_q      <= W_IDLE;
         cnt_q      <= '0;
         ovl_q      <= 1'b0;
         wbank_q    <= 1'b0;
         s_q        <= '0;
         len_err_q  <= 1'b0;
         ovf_q      <= 1'b0;
         bst_q      <= '0;
         blen_q     <= '0;
         bsyn_q     <= '0;
         busy_q     <= 1'b0;
         rdst_q     <= R_IDLE;
         rd_bank_q  <= 1'b0;
         rd_cnt_q   <= '0;
         rd_last_q  <= '0;
         dout_val_q <= 1'b0;
         dout_sop_q <= 1'b0;
         dout_eop_q <= 1'b0;
         err_q      <= 1'b0;
         syn_q      <= '0;
      end else begin
         wst_q      <= wst_d;
         cnt_q      <= cnt_d;
         ovl_q      <= ovl_d;
         wbank_q    <= wbank_d;
         s_q        <= s_d;
         len_err_q  <= len_err_d;
         ovf_q      <= ovf_d;
         bst_q      <= bst_d;
         blen_q     <= blen_d;
         bsyn_q     <= bsyn_d;
         busy_q     <= busy_d;
         rdst_q     <= rdst_d;
         rd_bank_q  <= rd_bank_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_last_q  <= rd_last_d;
         dout_val_q <= dout_val_d;
         dout_sop_q <= dout_sop_d;
         dout_eop_q <= dout_eop_d;
         err_q      <= err_d;
         syn_q      <= syn_d;
      end
   end

   // frame buffer: plain synchronous RAM, no reset
   always_ff @(posedge clk) begin
      if (we)  mem[{wsel, waddr}] <= din;
      if (iss) rd_dat_q <= mem[{iss_bank, iss_addr}];
   end

   assign dout_val = dout_val_q;
   assign dout_sop = dout_sop_q;
   assign dout_eop = dout_eop_q;
   assign dout     = dout_val_q ? rd_dat_q : 8'h00;
   assign err      = err_q;
   assign syn      = syn_q;
   assign len_err  = len_err_q;
   assign ovf      = ovf_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_rs_syndrome_checker.sv
module tb_rs_syndrome_checker;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        din_val = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        dout_val, dout_sop, dout_eop, err, len_err, ovf, busy;
   logic [7:0]  dout;
   logic [63:0] syn;

   rs_syndrome_checker dut (
      .clk(clk), .rst_n(rst_n), .din_val(din_val), .din_sop(din_sop), .din_eop(din_eop), .din(din),
      .dout_val(dout_val), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout(dout),
      .err(err), .syn(syn), .len_err(len_err), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic        err;
      logic [63:0] syn;
      logic [7:0]  dat;
   } sb_item_t;

   sb_item_t   sbq[$];
   sb_item_t   mon_e;
   int         errors = 0, checks = 0;
   int         len_err_cnt = 0, ovf_cnt = 0, last_len_err_cyc = -1, last_sop_cyc = -1;
   int         gap_cnt = 0, eop_cyc = 0;
   bit         in_frm = 1'b0;
   logic [7:0] fb [0:299];
   int         fb_len = 0;
   logic [7:0] gen [0:8];
   logic [7:0] expt [0:254];

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // GF(256) multiply, MSB-first double-and-add
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
         if (a[i]) r = r ^ b;
      end
      return r;
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      if (len_err) begin len_err_cnt++; last_len_err_cyc = cyc; end
      if (ovf) ovf_cnt++;
      if (dout_val) begin
         if (dout_sop) begin last_sop_cyc = cyc; in_frm = 1'b1; gap_cnt = 0; end
         if (sbq.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            mon_e = sbq.pop_front();
            chk("out_symbol", {dout_sop, dout_eop, err, syn, dout}, mon_e);
         end
         if (dout_eop) begin
            chk("frame_gap", gap_cnt, 0);
            in_frm = 1'b0;
         end
      end else begin
         if (in_frm) gap_cnt++;
         chk("idle_quiet", {dout_sop, dout_eop, err, syn, dout}, 0);
      end
   end

   // systematic encoder model: data then remainder of m(x)x^8 / g(x)
   task automatic build_coded(input int k, input int mode);
      logic [7:0] p [0:7];
      logic [7:0] d, f;
      for (int j = 0; j < 8; j++) p[j] = 8'h00;
      for (int i = 0; i < k; i++) begin
         d = (mode == 0) ? 8'(i) : (mode == 1) ? 8'hAA : 8'(i * 37 + 5);
         fb[i] = d;
         f = d ^ p[7];
         for (int j = 7; j > 0; j--) p[j] = p[j-1] ^ gmul(f, gen[j]);
         p[0] = gmul(f, gen[0]);
      end
      for (int j = 0; j < 8; j++) fb[k + j] = p[7 - j];
      fb_len = k + 8;
   endtask

   task automatic push_expect(input int k, input logic e, input logic [63:0] s);
      sb_item_t it;
      for (int i = 0; i < k; i++) begin
         it.sop = (i == 0);
         it.eop = (i == k - 1);
         it.err = (i == k - 1) ? e : 1'b0;
         it.syn = (i == k - 1) ? s : 64'd0;
         it.dat = fb[i];
         sbq.push_back(it);
      end
   endtask

   task automatic drive_frame(input bit busy_chk, input logic busy_req);
      for (int i = 0; i < fb_len; i++) begin
         din_val = 1'b1;
         din_sop = (i == 0);
         din_eop = (i == fb_len - 1);
         din     = fb[i];
         if (i == 0 && busy_chk) chk("busy_at_sop", busy, busy_req);
         if (i == fb_len - 1) eop_cyc = cyc;
         @(posedge clk); #1;
      end
      din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk("drain", sbq.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] s2;
      int le0, ov0;
      expt[0] = 8'h01;
      for (int i = 1; i < 255; i++) expt[i] = gmul(expt[i-1], 8'h02);
      gen[0] = 8'h01;
      for (int j = 1; j <= 8; j++) gen[j] = 8'h00;
      for (int r = 1; r <= 8; r++) begin
         for (int j = 8; j > 0; j--) gen[j] = gen[j-1] ^ gmul(gen[j], expt[r]);
         gen[0] = gmul(gen[0], expt[r]);
      end

      // reset state
      #12;
      chk("rst_dout_val", dout_val, 0);
      chk("rst_busy", busy, 0);
      chk("rst_syn", syn, 0);
      chk("rst_flags", {dout_sop, dout_eop, err, len_err, ovf}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;

      // 1: full-length clean codeword, latency check
      build_coded(247, 0);
      push_expect(247, 1'b0, 64'd0);
      drive_frame(1'b1, 1'b0);
      wait_drain();
      chk("sop_latency", last_sop_cyc, eop_cyc + 2);

      // 2: single error at index 100 (degree 154)
      build_coded(247, 0);
      fb[100] = fb[100] ^ 8'h01;
      for (int i = 1; i <= 8; i++) s2[8*(i-1) +: 8] = expt[(154 * i) % 255];
      push_expect(247, 1'b1, s2);
      drive_frame(1'b0, 1'b0);
      wait_drain();

      // 3: shortened code, N=28
      build_coded(20, 1);
      push_expect(20, 1'b0, 64'd0);
      drive_frame(1'b0, 1'b0);
      wait_drain();

      // 4: three N=255 frames back to back
      for (int f = 0; f < 3; f++) begin
         build_coded(247, (f == 1) ? 0 : 2);
         push_expect(247, 1'b0, 64'd0);
         drive_frame(1'b1, 1'b0);
      end
      wait_drain();

      // 5: N=255, N=9, then sop while both banks are held
      ov0 = ovf_cnt;
      build_coded(247, 2);
      push_expect(247, 1'b0, 64'd0);
      drive_frame(1'b1, 1'b0);
      build_coded(1, 2);
      push_expect(1, 1'b0, 64'd0);
      drive_frame(1'b1, 1'b0);
      build_coded(12, 0);
      drive_frame(1'b1, 1'b1);
      wait_drain();
      chk("ovf_count", ovf_cnt - ov0, 1);
      build_coded(30, 2);
      push_expect(30, 1'b0, 64'd0);
      drive_frame(1'b1, 1'b0);
      wait_drain();

      // 6a: N=8 too short
      le0 = len_err_cnt;
      for (int i = 0; i < 8; i++) fb[i] = 8'(i + 1);
      fb_len = 8;
      drive_frame(1'b0, 1'b0);
      repeat (3) @(posedge clk); #1;
      chk("len_err_short", len_err_cnt - le0, 1);
      chk("len_err_timing", last_len_err_cyc, eop_cyc + 1);

      // 6b: N=300 overlength
      le0 = len_err_cnt;
      for (int i = 0; i < 300; i++) fb[i] = 8'(i);
      fb_len = 300;
      drive_frame(1'b0, 1'b0);
      repeat (3) @(posedge clk); #1;
      chk("len_err_long", len_err_cnt - le0, 1);
      chk("long_busy", busy, 0);

      // 6c: reset in the middle of a frame
      for (int i = 0; i < 50; i++) begin
         din_val = 1'b1; din_sop = (i == 0); din_eop = 1'b0; din = 8'(i);
         @(posedge clk); #1;
      end
      din_val = 1'b0; din_sop = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {dout_val, dout_sop, dout_eop, err, syn, len_err, ovf, busy}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      build_coded(40, 0);
      push_expect(40, 1'b0, 64'd0);
      drive_frame(1'b1, 1'b0);
      wait_drain();
      chk("sop_latency_after_rst", last_sop_cyc, eop_cyc + 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
